legv8_multicycle_core: RTL
==========================

// Module: legv8_multicycle_core
// PURPOSE
//   Multi-cycle LEGv8 core. Width-parametrised successor to the single-cycle datapath.
//   One FSM sequences fetch/decode/execute/memory/writeback and shares one memory port.
//   The memory port uses a req/ready handshake, so wait-state memories are supported.
//   Sits between the top-level clock/reset and a unified instruction/data memory.
// PARAMETERS
//   DATA_W    64   register, ALU, PC and address width (>=32)
//   PC_RESET  0    PC value loaded on reset
// PORTS
//   clk        in   1       system clock, rising edge
//   reset      in   1       asynchronous, active-low reset
//   mem_req    out  1       memory request, held until mem_ready
//   mem_we     out  1       1 = store, 0 = read (fetch or load)
//   mem_addr   out  DATA_W  byte address
//   mem_wdata  out  DATA_W  store data
//   mem_rdata  in   DATA_W  read data; instruction = mem_rdata[31:0]
//   mem_ready  in   1       completes the request in the current cycle
//   pc_out     out  DATA_W  PC of the instruction in flight
//   retire     out  1       1-cycle pulse when an instruction completes
//   halted     out  1       core stopped (illegal opcode)
// BEHAVIOUR
// - Reset (reset=0, async): state=FETCH; PC=PC_RESET; IR=0; X0..X30=0.
//   Outputs at reset: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, retire=0, halted=0.
//   mem_req rises in the first cycle after reset deasserts.
// - Supported ops, decoded on IR[31:21]:
//     ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000
//     LDUR 11111000010, STUR 11111000000, CBZ IR[31:24]=10110100, B IR[31:26]=000101
// - Register fields: Rd/Rt=[4:0], Rn=[9:5], Rm=[20:16].
//   Register 31 is XZR: it reads 0 and writes to it are discarded.
// - D-format offset: sext(IR[20:12]).
//   CBZ offset: sext(IR[23:5])<<2. B offset: sext(IR[25:0])<<2.
//   All offsets are sign-extended to DATA_W.
// - FSM states:
//   FETCH: mem_req=1, mem_we=0, mem_addr=PC.
//     On mem_ready, IR<=mem_rdata[31:0] and go to DECODE. Otherwise stay.
//   DECODE: A<=R[Rn].
//     B<=R[Rm] for R-format; B<=R[Rt] for STUR and CBZ.
//     Unknown opcode -> HALT.
//   EXEC: ALU result is computed modulo 2^DATA_W; carry and overflow are ignored.
//     R-format -> WB.
//     LDUR/STUR: ALUOUT<=A+offset -> MEM.
//     CBZ: PC<=(B==0)?PC+off:PC+4, retire, -> FETCH.
//     B: PC<=PC+off, retire, -> FETCH.
//   MEM: mem_req=1, mem_addr=ALUOUT, mem_we=STUR, mem_wdata=B.
//     Stay until mem_ready.
//     STUR: PC<=PC+4, retire, -> FETCH. LDUR: MDR<=mem_rdata, -> WB.
//   WB: R[Rd]<=ALUOUT (R-format) or MDR (LDUR). PC<=PC+4, retire, -> FETCH.
//   HALT: halted=1, mem_req=0. Terminal until reset.
// - Handshake rules:
//   - mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and mem_ready=0.
//   - mem_req is 0 in DECODE, EXEC, WB and HALT.
//   - mem_ready seen while mem_req=0 is ignored.
// - Latency with zero-wait memory (mem_ready tied 1):
//   R-format 4 cycles, LDUR 5, STUR 4, CBZ/B 3.
//   Each wait cycle adds 1.
// - Branch target arithmetic wraps modulo 2^DATA_W. A branch to its own PC (off=0) is legal.
// - LDUR with Rt=31 performs the read and discards the data.
// - Reset asserted mid-transaction aborts it immediately. No register or PC update occurs.
// - pc_out = PC at all times. retire is asserted in the cycle PC updates.
// TESTING
// - ADD X1,X31,X31 then SUB X2,X1,X1 (ready=1) -> X1=0, X2=0.
//   Retire at cycles 4 and 8 after reset release. PC=8.
// - Preload mem[0x100]=0xDEADBEEF; X3=0x100; LDUR X4,[X3,#0] with 3 wait states
//   -> X4=0xDEADBEEF. Retire after 8 cycles.
//   Address stable during all waits.
// - STUR X4,[X3,#8] -> one write with mem_addr=0x108, mem_wdata=X4, mem_we=1.
//   PC+4.
// - CBZ X31,#-1 at PC=0x20 -> PC=0x1C.
//   CBZ X4 (nonzero) -> PC=0x24.
//   B #0x3FFFFFF at PC=0 -> PC=0xFF..FC (wrap).
// - Illegal word 0xFFFFFFFF -> halted=1 after the DECODE cycle.
//   mem_req=0 thereafter. reset=0 -> halted=0, PC=PC_RESET.
// - Assert reset during a MEM wait (STUR pending)
//   -> mem_req=0 immediately. No write. PC=PC_RESET.

Source files
------------

// File: rtl/legv8_multicycle_core.sv
// Multi-cycle LEGv8 core: one FSM walks FETCH/DECODE/EXEC/MEM/WB over a single
// req/ready memory port shared by instruction fetch and data access.
module legv8_multicycle_core #(
  parameter int                DATA_W   = 64,
  parameter logic [DATA_W-1:0] PC_RESET = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  output logic [DATA_W-1:0] pc_out_o,
  output logic              retire_o,
  output logic              halted_o
);
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] pc_q, a_q, b_q, aluout_q, mdr_q;
  logic [31:0]       ir_q;
  // Entry 31 is never written, so it always reads back as XZR.
  logic [DATA_W-1:0] regs_q [32];

  logic [4:0]  rd, rn, rm;
  logic [10:0] opc;
  logic op_add, op_sub, op_and, op_orr, op_ldur, op_stur, op_cbz, op_b, is_r, legal;
  logic [DATA_W-1:0] d_off, cbz_off, b_off, pc_plus4, alu_r;

  assign rd  = ir_q[4:0];
  assign rn  = ir_q[9:5];
  assign rm  = ir_q[20:16];
  assign opc = ir_q[31:21];

  assign op_add  = (opc == 11'b10001011000);
  assign op_sub  = (opc == 11'b11001011000);
  assign op_and  = (opc == 11'b10001010000);
  assign op_orr  = (opc == 11'b10101010000);
  assign op_ldur = (opc == 11'b11111000010);
  assign op_stur = (opc == 11'b11111000000);
  assign op_cbz  = (ir_q[31:24] == 8'b10110100);
  assign op_b    = (ir_q[31:26] == 6'b000101);
  assign is_r    = op_add | op_sub | op_and | op_orr;
  assign legal   = is_r | op_ldur | op_stur | op_cbz | op_b;

  assign d_off    = {{(DATA_W-9){ir_q[20]}}, ir_q[20:12]};
  assign cbz_off  = {{(DATA_W-21){ir_q[23]}}, ir_q[23:5], 2'b00};
  assign b_off    = {{(DATA_W-28){ir_q[25]}}, ir_q[25:0], 2'b00};
  assign pc_plus4 = pc_q + DATA_W'(4);

  always_comb begin
    alu_r = a_q + b_q;
    if (op_sub)      alu_r = a_q - b_q;
    else if (op_and) alu_r = a_q & b_q;
    else if (op_orr) alu_r = a_q | b_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready_i) state_d = S_DECODE;
      S_DECODE: state_d = legal ? S_EXEC : S_HALT;
      S_EXEC:   state_d = is_r ? S_WB : (op_ldur | op_stur) ? S_MEM : S_FETCH;
      S_MEM:    if (mem_ready_i) state_d = op_stur ? S_FETCH : S_WB;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_FETCH;
      pc_q     <= PC_RESET;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_FETCH:  if (mem_ready_i) ir_q <= mem_rdata_i[31:0];
        S_DECODE: begin
          a_q <= regs_q[rn];
          b_q <= is_r ? regs_q[rm] : regs_q[rd];
        end
        S_EXEC: begin
          if (is_r)                   aluout_q <= alu_r;
          else if (op_ldur | op_stur) aluout_q <= a_q + d_off;
          else if (op_cbz)            pc_q     <= (b_q == '0) ? pc_q + cbz_off : pc_plus4;
          else                        pc_q     <= pc_q + b_off;
        end
        S_MEM: if (mem_ready_i) begin
          if (op_stur) pc_q  <= pc_plus4;
          else         mdr_q <= mem_rdata_i;
        end
        S_WB: begin
          if (rd != 5'd31) regs_q[rd] <= op_ldur ? mdr_q : aluout_q;
          pc_q <= pc_plus4;
        end
        default: ;
      endcase
    end
  end

  // Gating with rst_ni drops a pending request the instant reset asserts.
  assign mem_req_o   = rst_ni && (state_q == S_FETCH || state_q == S_MEM);
  assign mem_we_o    = mem_req_o && (state_q == S_MEM) && op_stur;
  assign mem_addr_o  = !mem_req_o ? '0 : (state_q == S_MEM) ? aluout_q : pc_q;
  assign mem_wdata_o = mem_we_o ? b_q : '0;
  assign retire_o    = (state_q == S_EXEC && (op_cbz | op_b)) ||
                       (state_q == S_MEM && op_stur && mem_ready_i) ||
                       (state_q == S_WB);
  assign halted_o    = (state_q == S_HALT);
  assign pc_out_o    = pc_q;
endmodule
